// File: rtl/prog_oscillator.sv
// prog_oscillator: synchronous programmable square-wave oscillator.
//
// Period and high time are programmed through shadow registers (load strobe) and only take
// effect when the oscillator starts or crosses a period boundary, so the waveform never
// changes mid-period. Runs continuously while enable is high, or in burst mode emits a fixed
// number of periods and then holds until enable is released.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   enable     run request (level)
//   load       1-cycle strobe capturing period_in/high_in/burst_in/mode into shadow regs
//   period_in  period in clocks (<2 treated as 2)
//   high_in    high clocks per period (0 => always low, >= period => always high)
//   burst_in   periods per burst (0 treated as 1)
//   mode       0 = continuous, 1 = burst
//   out        registered oscillator output
//   running    high while in RUN or DRAIN
//   tick       1-cycle pulse on the first clock of each period
//   done       1-cycle pulse when returning to IDLE/HOLD
module prog_oscillator #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned BURST_W    = 8,
  parameter int unsigned DEF_PERIOD = 10,
  parameter int unsigned DEF_HIGH   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               load,
  input  logic [CNT_W-1:0]   period_in,
  input  logic [CNT_W-1:0]   high_in,
  input  logic [BURST_W-1:0] burst_in,
  input  logic               mode,
  output logic               out,
  output logic               running,
  output logic               tick,
  output logic               done
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StHold} state_e;

  state_e state_q, state_d;

  // Shadow (programmed) registers, raw values
  logic [CNT_W-1:0]   sh_period_q, sh_period_d;
  logic [CNT_W-1:0]   sh_high_q, sh_high_d;
  logic [BURST_W-1:0] sh_burst_q, sh_burst_d;
  logic               sh_mode_q, sh_mode_d;

  // Active registers, already clamped
  logic [CNT_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]   high_q, high_d;
  logic               mode_q, mode_d;

  logic [CNT_W-1:0]   phase_q, phase_d;
  logic [BURST_W-1:0] bcnt_q, bcnt_d;
  logic               out_q, out_d;
  logic               tick_q, tick_d;
  logic               done_q, done_d;

  logic [CNT_W-1:0]   cl_period, cl_high, phase_nxt;
  logic [BURST_W-1:0] cl_burst;
  logic               in_run, at_boundary, burst_last, restart;

  // Clamping happens on the way from shadow to active
  assign cl_period = (sh_period_q < CNT_W'(2)) ? CNT_W'(2) : sh_period_q;
  assign cl_high   = (sh_high_q > cl_period) ? cl_period : sh_high_q;
  assign cl_burst  = (sh_burst_q == '0) ? BURST_W'(1) : sh_burst_q;

  assign in_run      = (state_q == StRun) || (state_q == StDrain);
  assign at_boundary = (phase_q == period_q - CNT_W'(1));
  assign phase_nxt   = phase_q + CNT_W'(1);
  assign burst_last  = mode_q && (bcnt_q == '0);

  // A new period starts either from IDLE or at a boundary that keeps running
  assign restart = ((state_q == StIdle) && enable) ||
                   (in_run && at_boundary && enable && !burst_last);

  // State register (and all other flops)
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      sh_period_q <= CNT_W'(DEF_PERIOD);
      sh_high_q   <= CNT_W'(DEF_HIGH);
      sh_burst_q  <= BURST_W'(1);
      sh_mode_q   <= 1'b0;
      period_q    <= CNT_W'(DEF_PERIOD);
      high_q      <= CNT_W'(DEF_HIGH);
      mode_q      <= 1'b0;
      phase_q     <= '0;
      bcnt_q      <= '0;
      out_q       <= 1'b0;
      tick_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_period_q <= sh_period_d;
      sh_high_q   <= sh_high_d;
      sh_burst_q  <= sh_burst_d;
      sh_mode_q   <= sh_mode_d;
      period_q    <= period_d;
      high_q      <= high_d;
      mode_q      <= mode_d;
      phase_q     <= phase_d;
      bcnt_q      <= bcnt_d;
      out_q       <= out_d;
      tick_q      <= tick_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (enable) state_d = StRun;
      end
      StRun, StDrain: begin
        if (at_boundary) begin
          if (!enable)        state_d = StIdle;
          else if (burst_last) state_d = StHold;
          else                 state_d = StRun;
        end else begin
          // DRAIN finishes the current period; re-enable returns to RUN seamlessly
          state_d = enable ? StRun : StDrain;
        end
      end
      StHold: begin
        if (!enable) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: shadow capture, active copy, phase/burst counters, registered outputs
  always_comb begin
    sh_period_d = sh_period_q;
    sh_high_d   = sh_high_q;
    sh_burst_d  = sh_burst_q;
    sh_mode_d   = sh_mode_q;
    period_d    = period_q;
    high_d      = high_q;
    mode_d      = mode_q;
    phase_d     = phase_q;
    bcnt_d      = bcnt_q;
    out_d       = 1'b0;
    tick_d      = 1'b0;
    done_d      = 1'b0;

    // The copy below reads the old shadow values, so a load coinciding with a boundary
    // only takes effect one period later.
    if (load) begin
      sh_period_d = period_in;
      sh_high_d   = high_in;
      sh_burst_d  = burst_in;
      sh_mode_d   = mode;
    end

    if (restart) begin
      period_d = cl_period;
      high_d   = cl_high;
      mode_d   = sh_mode_q;
      phase_d  = '0;
      tick_d   = 1'b1;
      out_d    = (cl_high != '0);
      // Continue an ongoing burst; anything else starts a fresh burst count
      bcnt_d   = (in_run && mode_q) ? bcnt_q - BURST_W'(1) : cl_burst - BURST_W'(1);
    end else if (in_run && !at_boundary) begin
      phase_d = phase_nxt;
      out_d   = (phase_nxt < high_q);
    end else if (in_run) begin
      phase_d = '0;
      done_d  = 1'b1;
    end
  end

  // Output logic
  always_comb begin
    running = in_run;
    out     = out_q;
    tick    = tick_q;
    done    = done_q;
  end

endmodule

// File: tb/tb_prog_oscillator.sv
// Self-checking bench for prog_oscillator: a cycle-level reference model predicts
// {out, running, tick, done} whenever stimulus is applied; the prediction is queued and
// compared once the DUT has clocked. Directed scenarios add explicit waveform checks.
module tb_prog_oscillator;
  localparam int unsigned CW = 16;
  localparam int unsigned BW = 8;

  logic          clk = 1'b0;
  logic          reset, enable, load, mode;
  logic [CW-1:0] period_in, high_in;
  logic [BW-1:0] burst_in;
  logic          out, running, tick, done;

  always #5 clk = ~clk;

  prog_oscillator #(
    .CNT_W(CW), .BURST_W(BW), .DEF_PERIOD(10), .DEF_HIGH(5)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load),
    .period_in(period_in), .high_in(high_in), .burst_in(burst_in), .mode(mode),
    .out(out), .running(running), .tick(tick), .done(done)
  );

  int n_vec = 0;
  int n_bad = 0;
  logic [3:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: st 0=idle 1=run 2=drain 3=hold
  int          m_st;
  int unsigned m_ph, m_p, m_h, m_b, m_cnt;
  bit          m_bm, m_out, m_tick, m_done;
  int unsigned s_p, s_h, s_b;
  bit          s_m;

  task automatic model_reset();
    m_st = 0; m_ph = 0; m_p = 10; m_h = 5; m_bm = 0; m_b = 1; m_cnt = 0;
    s_p = 10; s_h = 5; s_b = 1; s_m = 0;
    m_out = 0; m_tick = 0; m_done = 0;
  endtask

  task automatic model_take();
    int unsigned p;
    p = (s_p < 2) ? 2 : s_p;
    m_p = p;
    m_h = (s_h > p) ? p : s_h;
    m_bm = s_m;
  endtask

  task automatic model_step(input bit en, input bit ld, input int unsigned pi,
                            input int unsigned hi, input int unsigned bi, input bit md,
                            input bit rst);
    if (rst) begin
      model_reset();
      return;
    end
    m_tick = 0;
    m_done = 0;
    case (m_st)
      0: begin
        m_out = 0;
        if (en) begin
          m_b = (s_b == 0) ? 1 : s_b;
          m_cnt = 1;
          model_take();
          m_ph = 0; m_tick = 1; m_out = (m_h != 0); m_st = 1;
        end
      end
      1, 2: begin
        if (m_ph + 1 == m_p) begin
          if (!en) begin
            m_st = 0; m_done = 1; m_out = 0; m_ph = 0;
          end else if (m_bm && m_cnt >= m_b) begin
            m_st = 3; m_done = 1; m_out = 0; m_ph = 0;
          end else begin
            if (m_bm) m_cnt++;
            else begin
              m_b = (s_b == 0) ? 1 : s_b;
              m_cnt = 1;
            end
            model_take();
            m_ph = 0; m_tick = 1; m_out = (m_h != 0); m_st = 1;
          end
        end else begin
          m_ph++;
          m_out = (m_ph < m_h);
          m_st = en ? 1 : 2;
        end
      end
      default: begin
        m_out = 0;
        if (!en) m_st = 0;
      end
    endcase
    if (ld) begin
      s_p = pi; s_h = hi; s_b = bi; s_m = md;
    end
  endtask

  // Apply current inputs for one clock, predict, then compare after the edge
  task automatic step(input string tag);
    logic [3:0] e;
    model_step(enable, load, period_in, high_in, burst_in, mode, reset);
    exp_q.push_back({m_out, (m_st == 1) || (m_st == 2), m_tick, m_done});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq(tag, {28'd0, out, running, tick, done}, {28'd0, e});
  endtask

  task automatic do_load(input int unsigned p, input int unsigned h, input int unsigned b,
                         input bit md, input string tag);
    period_in = CW'(p); high_in = CW'(h); burst_in = BW'(b); mode = md;
    load = 1'b1;
    step(tag);
    load = 1'b0;
  endtask

  task automatic idle_out(input int n);
    enable = 1'b0;
    repeat (n) step("drain");
  endtask

  int ticks, dones;

  initial begin
    model_reset();
    reset = 1'b1; enable = 1'b0; load = 1'b0; mode = 1'b0;
    period_in = '0; high_in = '0; burst_in = '0;

    // 1: reset, then P=4 H=1 continuous
    step("reset0");
    step("reset1");
    reset = 1'b0;
    do_load(4, 1, 1, 0, "t1_load");
    enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step("t1");
      check_eq("t1_out", out, (i % 4) == 0);
      check_eq("t1_tick", tick, (i % 4) == 0);
    end
    idle_out(6);

    // 2: P=6 H=3, drop enable at phase 1
    do_load(6, 3, 1, 0, "t2_load");
    enable = 1'b1;
    step("t2");
    step("t2");
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step("t2_drain");
      check_eq("t2_done", done, i == 4);
      check_eq("t2_running", running, i < 4);
    end

    // 3: burst of 3, P=4 H=2, enable held
    do_load(4, 2, 3, 1, "t3_load");
    enable = 1'b1;
    ticks = 0; dones = 0;
    for (int i = 0; i < 20; i++) begin
      step("t3");
      ticks += int'(tick);
      dones += int'(done);
    end
    check_eq("t3_ticks", ticks, 3);
    check_eq("t3_dones", dones, 1);
    check_eq("t3_hold", running, 1'b0);
    enable = 1'b0;
    step("t3_rel");
    step("t3_rel");
    enable = 1'b1;
    step("t3_retrig");
    check_eq("t3_retrig_run", running, 1'b1);
    idle_out(10);

    // 4: clamps
    do_load(0, 1, 1, 0, "t4a_load");
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step("t4a");
      check_eq("t4a_out", out, (i % 2) == 0);
      check_eq("t4a_tick", tick, (i % 2) == 0);
    end
    idle_out(4);
    do_load(5, 0, 1, 0, "t4b_load");
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step("t4b");
      check_eq("t4b_out", out, 1'b0);
      check_eq("t4b_tick", tick, (i % 5) == 0);
    end
    idle_out(8);
    do_load(5, 100, 1, 0, "t4c_load");
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step("t4c");
      check_eq("t4c_out", out, 1'b1);
      check_eq("t4c_tick", tick, (i % 5) == 0);
    end
    idle_out(8);

    // 5: reload mid-period and on the boundary
    do_load(4, 2, 1, 0, "t5_load");
    enable = 1'b1;
    step("t5");
    step("t5");
    do_load(8, 4, 1, 0, "t5_mid_load");
    step("t5");
    for (int i = 0; i < 8; i++) begin
      step("t5_p8");
      check_eq("t5_p8_tick", tick, i == 0);
      check_eq("t5_p8_out", out, i < 4);
    end
    do_load(3, 1, 1, 0, "t5_bnd_load");
    check_eq("t5_bnd_tick", tick, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step("t5_late");
      check_eq("t5_late_tick", tick, i == 7);
      check_eq("t5_late_out", out, (i < 3) || (i == 7));
    end
    for (int i = 0; i < 3; i++) begin
      step("t5_p3");
      check_eq("t5_p3_tick", tick, i == 2);
    end
    idle_out(5);

    // 6: reset mid-high and mid-burst
    do_load(6, 3, 2, 0, "t6_load");
    enable = 1'b1;
    step("t6");
    step("t6");
    reset = 1'b1;
    step("t6_rst_high");
    check_eq("t6_rst_out", {out, running, done}, 3'b000);
    reset = 1'b0;
    enable = 1'b0;
    step("t6");
    do_load(4, 2, 3, 1, "t6_burst_load");
    enable = 1'b1;
    repeat (6) step("t6_burst");
    reset = 1'b1;
    step("t6_rst_burst");
    check_eq("t6_rstb_out", {out, running, done}, 3'b000);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step("t6_def");
      check_eq("t6_def_out", out, (i % 10) < 5);
      check_eq("t6_def_tick", tick, (i % 10) == 0);
    end
    idle_out(15);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      enable    = ($urandom_range(0, 9) < 7);
      load      = ($urandom_range(0, 9) == 0);
      reset     = ($urandom_range(0, 99) == 0);
      period_in = CW'($urandom_range(0, 9));
      high_in   = CW'($urandom_range(0, 10));
      burst_in  = BW'($urandom_range(0, 4));
      mode      = 1'($urandom_range(0, 1));
      step("rand");
    end
    load = 1'b0;
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
